// File: rtl/pipe_stage.sv
// pipe_stage: reusable pipeline-stage register with valid/ready flow control.
//
// Carries a control field, which reads as zero whenever the stage holds a bubble, and a data
// payload, which holds its last value. SKID=1 adds a second (skid) entry so that in_ready
// depends only on registered state. SKID=0 is a single register with a combinational
// in_ready.
//
// Parameters:
//   CTRL_W  width of the control field (>=1)
//   DATA_W  width of the payload (>=1)
//   SKID    1 = two-entry skid buffer, registered in_ready; 0 = single register
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (priority over flush)
//   flush      discard all held entries at the next edge
//   in_valid   upstream offers an entry
//   in_ready   stage can accept an entry this cycle
//   in_ctrl    control field of the offered entry
//   in_data    payload of the offered entry
//   out_valid  downstream entry is valid
//   out_ready  downstream accepts the entry
//   out_ctrl   control field, zero whenever out_valid=0
//   out_data   payload, holds its last value when out_valid=0
//   occupancy  number of held entries (0..2)

module pipe_stage #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 111,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Main register (drives out_*).
  logic              r_m_valid;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [DATA_W-1:0] r_m_data;
  logic              w_m_valid_nxt;
  logic [CTRL_W-1:0] w_m_ctrl_nxt;
  logic [DATA_W-1:0] w_m_data_nxt;

  logic w_accept;
  logic w_drain;

  assign w_accept  = in_valid & in_ready;
  assign w_drain   = r_m_valid & out_ready;

  assign out_valid = r_m_valid;
  assign out_ctrl  = r_m_ctrl;
  assign out_data  = r_m_data;

  if (SKID != 0) begin : g_skid
    logic              r_s_valid;
    logic [CTRL_W-1:0] r_s_ctrl;
    logic [DATA_W-1:0] r_s_data;
    logic              w_s_valid_nxt;
    logic [CTRL_W-1:0] w_s_ctrl_nxt;
    logic [DATA_W-1:0] w_s_data_nxt;

    // Registered ready: S empty means there is room for one more entry even if the
    // downstream stalls in this same cycle.
    assign in_ready  = ~r_s_valid;
    assign occupancy = 2'(r_m_valid) + 2'(r_s_valid);

    always_comb begin
      w_m_valid_nxt = r_m_valid;
      w_m_ctrl_nxt  = r_m_ctrl;
      w_m_data_nxt  = r_m_data;
      w_s_valid_nxt = r_s_valid;
      w_s_ctrl_nxt  = r_s_ctrl;
      w_s_data_nxt  = r_s_data;

      if (flush) begin
        // Data registers keep their values; only valids and ctrl are cleared.
        w_m_valid_nxt = 1'b0;
        w_m_ctrl_nxt  = '0;
        w_s_valid_nxt = 1'b0;
        w_s_ctrl_nxt  = '0;
      end else if (!r_m_valid) begin
        // S is never occupied while M is empty.
        if (w_accept) begin
          w_m_valid_nxt = 1'b1;
          w_m_ctrl_nxt  = in_ctrl;
          w_m_data_nxt  = in_data;
        end
      end else if (w_drain) begin
        if (r_s_valid) begin
          // in_ready is low while S is full, so no accept can coincide here.
          w_m_valid_nxt = 1'b1;
          w_m_ctrl_nxt  = r_s_ctrl;
          w_m_data_nxt  = r_s_data;
          w_s_valid_nxt = 1'b0;
          w_s_ctrl_nxt  = '0;
        end else if (w_accept) begin
          w_m_valid_nxt = 1'b1;
          w_m_ctrl_nxt  = in_ctrl;
          w_m_data_nxt  = in_data;
        end else begin
          w_m_valid_nxt = 1'b0;
          w_m_ctrl_nxt  = '0;
        end
      end else if (w_accept) begin
        // M stalled: park the new entry in S.
        w_s_valid_nxt = 1'b1;
        w_s_ctrl_nxt  = in_ctrl;
        w_s_data_nxt  = in_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_m_valid <= 1'b0;
        r_m_ctrl  <= '0;
        r_m_data  <= '0;
        r_s_valid <= 1'b0;
        r_s_ctrl  <= '0;
        r_s_data  <= '0;
      end else begin
        r_m_valid <= w_m_valid_nxt;
        r_m_ctrl  <= w_m_ctrl_nxt;
        r_m_data  <= w_m_data_nxt;
        r_s_valid <= w_s_valid_nxt;
        r_s_ctrl  <= w_s_ctrl_nxt;
        r_s_data  <= w_s_data_nxt;
      end
    end
  end else begin : g_noskid
    // The only combinational path in this mode: out_ready -> in_ready.
    assign in_ready  = ~r_m_valid | out_ready;
    assign occupancy = 2'(r_m_valid);

    always_comb begin
      w_m_valid_nxt = r_m_valid;
      w_m_ctrl_nxt  = r_m_ctrl;
      w_m_data_nxt  = r_m_data;

      if (flush) begin
        w_m_valid_nxt = 1'b0;
        w_m_ctrl_nxt  = '0;
      end else if (w_accept) begin
        w_m_valid_nxt = 1'b1;
        w_m_ctrl_nxt  = in_ctrl;
        w_m_data_nxt  = in_data;
      end else if (w_drain) begin
        w_m_valid_nxt = 1'b0;
        w_m_ctrl_nxt  = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_m_valid <= 1'b0;
        r_m_ctrl  <= '0;
        r_m_data  <= '0;
      end else begin
        r_m_valid <= w_m_valid_nxt;
        r_m_ctrl  <= w_m_ctrl_nxt;
        r_m_data  <= w_m_data_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: drives a SKID=0 instance (index 0) and a SKID=1 instance (index 1) with
// independent stimulus and compares both against a FIFO-style reference model every cycle.

module tb_pipe_stage;

  localparam int CW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          vld [2];
  logic          rdy [2];
  logic          fl  [2];
  logic [CW-1:0] ctl [2];
  logic [DW-1:0] dat [2];
  logic          ir  [2];
  logic          ov  [2];
  logic [CW-1:0] oc  [2];
  logic [DW-1:0] od  [2];
  logic [1:0]    occ [2];

  pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_noskid (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(vld[0]), .in_ready(ir[0]),
    .in_ctrl(ctl[0]), .in_data(dat[0]), .out_valid(ov[0]), .out_ready(rdy[0]),
    .out_ctrl(oc[0]), .out_data(od[0]), .occupancy(occ[0])
  );

  pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(vld[1]), .in_ready(ir[1]),
    .in_ctrl(ctl[1]), .in_data(dat[1]), .out_valid(ov[1]), .out_ready(rdy[1]),
    .out_ctrl(oc[1]), .out_data(od[1]), .occupancy(occ[1])
  );

  // Reference model: an ordered list of held entries (capacity 2 with skid, 1 without)
  // plus the payload last presented at the head.
  int            cnt   [2];
  logic [CW-1:0] mctl  [2][2];
  logic [DW-1:0] mdat  [2][2];
  logic [DW-1:0] last  [2];
  bit            acc   [2];
  int            seq   [2];
  int            stall [2];
  bit            did   [2];
  int            checks = 0;
  int            errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready(input int k);
    if (k == 1) return cnt[k] < 2;
    return (cnt[k] == 0) || rdy[k];
  endfunction

  task automatic cycle();
    bit drn [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("k%0d_in_ready", k), 64'(ir[k]), 64'(exp_ready(k)));
      check_eq($sformatf("k%0d_out_valid", k), 64'(ov[k]), 64'(cnt[k] > 0));
      check_eq($sformatf("k%0d_out_ctrl", k), 64'(oc[k]),
               (cnt[k] > 0) ? 64'(mctl[k][0]) : 64'd0);
      check_eq($sformatf("k%0d_out_data", k), 64'(od[k]),
               (cnt[k] > 0) ? 64'(mdat[k][0]) : 64'(last[k]));
      check_eq($sformatf("k%0d_occupancy", k), 64'(occ[k]), 64'(cnt[k]));
      acc[k] = vld[k] && exp_ready(k) && !rst && !fl[k];
      drn[k] = (cnt[k] > 0) && rdy[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cnt[k]  = 0;
        last[k] = '0;
      end else if (fl[k]) begin
        cnt[k] = 0;
      end else begin
        if (drn[k]) begin
          mctl[k][0] = mctl[k][1];
          mdat[k][0] = mdat[k][1];
          cnt[k]--;
        end
        if (acc[k]) begin
          mctl[k][cnt[k]] = ctl[k];
          mdat[k][cnt[k]] = dat[k];
          cnt[k]++;
        end
      end
      if (cnt[k] > 0) last[k] = mdat[k][0];
    end
    #1;
  endtask

  task automatic drive_seq(input int k);
    dat[k] = DW'(seq[k]);
    ctl[k] = 8'h80 | CW'(seq[k]);
  endtask

  task automatic set_both(input logic v, input logic r, input logic [DW-1:0] d);
    for (int k = 0; k < 2; k++) begin
      vld[k] = v;
      rdy[k] = r;
      dat[k] = d;
      ctl[k] = 8'h80 | CW'(d);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b1; rdy[k] = 1'b1; fl[k] = 1'b0;
      ctl[k] = 8'hFF; dat[k] = 16'h5A5A;
      cnt[k] = 0; last[k] = '0; seq[k] = 0; stall[k] = 0; did[k] = 1'b0;
    end
    // First reset edge establishes a known state; then two checked reset cycles.
    @(posedge clk);
    #1;
    repeat (2) cycle();
    rst = 1'b0;

    // Streaming: entries 0..15, out_ready held high.
    for (int c = 0; c < 80 && (seq[0] < 16 || seq[1] < 16); c++) begin
      for (int k = 0; k < 2; k++) begin
        vld[k] = seq[k] < 16;
        drive_seq(k);
      end
      cycle();
      for (int k = 0; k < 2; k++) if (acc[k]) seq[k]++;
    end
    set_both(1'b0, 1'b1, '0);
    repeat (3) cycle();

    // Back-pressure: stall out_ready for 3 cycles once entry 4 is at the head.
    for (int k = 0; k < 2; k++) begin
      seq[k] = 0; stall[k] = 0; did[k] = 1'b0;
    end
    for (int c = 0; c < 80 && (seq[0] < 12 || seq[1] < 12 || cnt[0] > 0 || cnt[1] > 0); c++)
    begin
      for (int k = 0; k < 2; k++) begin
        if (!did[k] && cnt[k] > 0 && mdat[k][0] == 16'd4) begin
          stall[k] = 3;
          did[k]   = 1'b1;
        end
        rdy[k] = (stall[k] == 0);
        vld[k] = seq[k] < 12;
        drive_seq(k);
      end
      cycle();
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) seq[k]++;
        if (stall[k] > 0) stall[k]--;
      end
    end

    // Bubble: entry 1, one idle cycle, entry 2.
    set_both(1'b1, 1'b1, 16'd1);
    cycle();
    set_both(1'b0, 1'b1, 16'd1);
    cycle();
    set_both(1'b1, 1'b1, 16'd2);
    cycle();
    set_both(1'b0, 1'b1, '0);
    repeat (3) cycle();

    // Flush with entries held and entry 9 offered in the flush cycle.
    set_both(1'b1, 1'b0, 16'd7);
    cycle();
    set_both(1'b1, 1'b0, 16'd8);
    cycle();
    set_both(1'b1, 1'b0, 16'd9);
    fl[0] = 1'b1; fl[1] = 1'b1;
    cycle();
    fl[0] = 1'b0; fl[1] = 1'b0;
    set_both(1'b1, 1'b1, 16'd10);
    cycle();
    set_both(1'b0, 1'b1, '0);
    repeat (3) cycle();

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 150) == 0;
      for (int k = 0; k < 2; k++) begin
        vld[k] = ($urandom % 4) != 0;
        rdy[k] = ($urandom % 3) != 0;
        fl[k]  = ($urandom % 40) == 0;
        dat[k] = DW'($urandom);
        ctl[k] = CW'($urandom);
      end
      cycle();
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fl[k] = 1'b0; vld[k] = 1'b0; rdy[k] = 1'b1;
    end
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Generic, parametrised pipeline-stage register that replaces the hand-written per-stage register blocks (ID/EX-style) with one reusable component. It carries a control field, which is cleared whenever the stage holds a bubble, and a data payload, which holds its last value. Flow control is valid/ready with an optional two-entry skid buffer, so back-pressure no longer needs a global stall vector. It sits between any two pipeline stages, for example decode→execute or execute→memory.

## Interface
Parameters:
- CTRL_W, default 8: width of the control field (RegWrite, MemWrite, ALU op, …); must be ≥1.
- DATA_W, default 111: width of the payload (operands, immediate, register indices); must be ≥1.
- SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  discard all held entries at the next edge.
- in_valid  input  1  upstream offers an entry.
- in_ready  output  1  stage can accept an entry this cycle.
- in_ctrl  input  CTRL_W  control field of the offered entry.
- in_data  input  DATA_W  payload of the offered entry.
- out_valid  output  1  downstream entry is valid.
- out_ready  input  1  downstream accepts the entry.
- out_ctrl  output  CTRL_W  control field; all zeros whenever out_valid=0.
- out_data  output  DATA_W  payload; holds its last value when out_valid=0.
- occupancy  output  2  number of held entries (0..2; max 1 when SKID=0).

## Operation
- Accept = in_valid & in_ready. Drain = out_valid & out_ready. Entries leave in the order they were accepted. No entry is duplicated or lost, except on flush or reset.
- Main register (M) drives out_*. Skid register (S) exists only when SKID=1.
- Update rules, SKID=1, evaluated per clock edge when neither rst nor flush is asserted:
  - M empty: an accepted entry goes to M.
  - M full and drained, S full: S moves to M; an accepted entry goes to S. This case cannot occur, because in_ready=0 when S is full.
  - M full and drained, S empty: an accepted entry goes to M; with no accept, M becomes empty.
  - M full and not drained: an accepted entry goes to S.
- in_ready (SKID=1) = ~S_valid, registered. It depends only on state, never on out_ready in the same cycle.
- SKID=0: in_ready = ~out_valid | out_ready (combinational). An accepted entry loads M. A drain with no accept empties M.
- Bubble: whenever M becomes empty, its ctrl is loaded with zero in the same edge. S ctrl is likewise zeroed when S empties.
- flush: at the next edge M and S are emptied and ctrl is zeroed. Any entry accepted in the flush cycle is discarded. Flush takes priority over accept and drain. Data registers keep their values.
- rst: has priority over flush. At the next edge it clears M and S valids and all ctrl and data registers to zero.
- occupancy = M_valid + S_valid, registered state only.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
- in_ready after reset:
  - SKID=1: in_ready=1 from the first cycle after rst is deasserted. in_ready=1 while rst is asserted, but accepts are ignored during reset.
  - SKID=0: in_ready=1 after reset.
- Latency: an entry accepted at edge n appears on out_* after edge n (1 cycle) when M is empty or being drained.
- Throughput: 1 entry/cycle sustained when out_ready=1 continuously, in both modes.
- Back-pressure (SKID=1): after out_ready falls, the stage absorbs at most one more entry. in_ready falls after the edge that fills S.
- Recovery: S drains into M on the first drain edge. in_ready rises in the following cycle.
- Simultaneous accept and drain with occupancy=1: occupancy stays 1 and M takes the new entry.
- Simultaneous flush and out_ready=1: the current out_* entry still counts as delivered in that cycle. The downstream stage owns that decision.
- No combinational path from in_* to out_* in either mode. In SKID=0 the only combinational path is out_ready→in_ready.

## Test plan
- Reset: drive rst=1 for 2 cycles with in_valid=1 and in_ctrl=8'hFF. Required: out_valid=0, out_ctrl=0, out_data=0, occupancy=0 throughout; the first accept happens only after rst=0.
- Streaming, SKID=1: send 16 entries with in_data=0..15 and ctrl=8'h80|i, out_ready=1. Required: out_data=0..15 in order, one per cycle starting 1 cycle after the first accept; in_ready stays 1.
- Back-pressure: stream continuously; drop out_ready for 3 cycles starting when out_data=4. Required:
  - entry 5 is captured in S and occupancy=2;
  - in_ready=0 for the stall duration;
  - after out_ready returns, outputs continue 4,5,6,… with no gap, duplicate or loss.
- Bubble: send entries 1 and 2 separated by one cycle with in_valid=0, out_ready=1. Required: the cycle between them has out_valid=0, out_ctrl=0, and out_data still equal to 1.
- Flush: with occupancy=2 (entries 7,8) and in_valid=1 carrying 9, assert flush for 1 cycle. Required: the next cycle shows occupancy=0, out_valid=0, out_ctrl=0, and entry 9 never appears; the next accepted entry follows normally.
- SKID=0 build: repeat the streaming and back-pressure scenarios. Required: occupancy ≤1 and in_ready tracks ~out_valid|out_ready in the same cycle; the ordering checks must pass.
